// File: rtl/decoder_pkg.sv
// decoder_pkg: shared widths, FSM state type and one-hot helper for the
// decoder_seq block.
//   CODE_W  : input code width (4)
//   OUT_W   : one-hot output width (16)
//   state_t : sweep FSM states {IDLE, SWEEP}
//   onehot(): code -> word with exactly bit <code> set
package decoder_pkg;

    localparam int CODE_W = 4;
    localparam int OUT_W  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [OUT_W-1:0] word;
        word       = '0;
        word[code] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/decoder_4to16_comb.sv
// decoder_4to16_comb: purely combinational 4-to-16 one-hot decoder with enable.
// Ports:
//   code  in  4   code to decode
//   en    in  1   enable; when low the output is all zeros
//   d     out 16  one-hot word, bit <code> set when en is high
module decoder_4to16_comb
    import decoder_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic              en,
    output logic [OUT_W-1:0]  d
);

    assign d = en ? onehot(code) : '0;

endmodule

// File: rtl/decoder_seq.sv
// decoder_seq: registered 4-to-16 one-hot decoder with valid/ready handshakes
// and a built-in sweep that emits the one-hot words for codes 0..15 in order.
// Optional feature macro: DECODER_PARITY_EN (adds in_par / err ports and an
// even-parity check on IDLE inputs; failing inputs are handshaken but dropped).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           decode enable (sampled at each load)
//   a            input code
//   in_valid     a/en valid;  in_ready: decoder accepts a code this cycle
//   sweep_start  one-cycle request to emit codes 0..15 (IDLE only)
//   d, out_code  one-hot output word and the code that produced it
//   out_valid    d/out_code valid;  out_ready: downstream accepts
//   sweep_done   pulse during the handshake of the final sweep word
//   in_par, err  parity bit over a and sticky error flag (DECODER_PARITY_EN)
module decoder_seq
    import decoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CODE_W-1:0] a,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sweep_start,
    output logic [OUT_W-1:0]  d,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef DECODER_PARITY_EN
    input  logic              in_par,
    output logic              err,
`endif
    output logic              sweep_done
);

    state_t              state_reg;
    logic [CODE_W-1:0]   cnt_reg;
    logic                last_reg;   // word 15 has been loaded, waiting for its handshake
    logic [OUT_W-1:0]    d_reg;
    logic [CODE_W-1:0]   code_reg;
    logic                valid_reg;

    logic                reg_free;
    logic                sweep_phase;
    logic                sweep_load;
    logic                in_fire;
    logic                idle_load;
    logic                par_ok;
    logic                load;
    logic [CODE_W-1:0]   sel_code;
    logic [OUT_W-1:0]    dec_word;

    assign reg_free = !valid_reg || out_ready;
    assign in_ready = (state_reg == IDLE) && !sweep_start && reg_free;
    assign in_fire  = in_valid && in_ready;

    // The accepted sweep_start cycle already loads word 0 so that the sweep
    // words appear starting the cycle right after the request. cnt_reg is 0
    // whenever the FSM is in IDLE.
    assign sweep_phase = (state_reg == SWEEP) || sweep_start;
    assign sweep_load  = sweep_phase && !last_reg && reg_free;

`ifdef DECODER_PARITY_EN
    assign par_ok = ((^a) == in_par);
`else
    assign par_ok = 1'b1;
`endif

    assign idle_load = in_fire && par_ok;
    assign load      = idle_load || sweep_load;
    assign sel_code  = sweep_phase ? cnt_reg : a;

    decoder_4to16_comb u_dec (
        .code (sel_code),
        .en   (en),
        .d    (dec_word)
    );

    // Combinational on out_ready so the pulse coincides with the handshake.
    assign sweep_done = (state_reg == SWEEP) && last_reg && valid_reg && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            last_reg  <= 1'b0;
            d_reg     <= '0;
            code_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            if (load) begin
                d_reg     <= dec_word;
                code_reg  <= sel_code;
                valid_reg <= 1'b1;
            end else if (out_ready) begin
                valid_reg <= 1'b0;
            end

            if (sweep_load) begin
                cnt_reg <= cnt_reg + 1'b1;  // wraps to 0 after word 15
                if (cnt_reg == CODE_W'(OUT_W - 1)) begin
                    last_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (sweep_start) begin
                        state_reg <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (sweep_done) begin
                        state_reg <= IDLE;
                        last_reg  <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef DECODER_PARITY_EN
    logic err_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (in_fire && !par_ok) begin
            err_reg <= 1'b1;
        end
    end
    assign err = err_reg;
`endif

    assign d         = d_reg;
    assign out_code  = code_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: the driver pushes the expected word for
// every accepted input (or all 16 words of a sweep); an independent monitor
// pops and compares on each output handshake.
module tb_decoder_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  a;
    logic        in_valid;
    logic        in_ready;
    logic        sweep_start;
    logic [15:0] d;
    logic [3:0]  out_code;
    logic        out_valid;
    logic        out_ready;
    logic        sweep_done;
`ifdef DECODER_PARITY_EN
    logic        in_par;
    logic        err;
`endif

    decoder_seq dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .a           (a),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sweep_start (sweep_start),
        .d           (d),
        .out_code    (out_code),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef DECODER_PARITY_EN
        .in_par      (in_par),
        .err         (err),
`endif
        .sweep_done  (sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] word;
        logic        last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks           = 0;
    int   failures         = 0;
    int   rdy_mode         = 0;   // 0: ready high, 1: random, 2: ready low
    int   sweeps_started   = 0;
    int   sweeps_done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_word(input logic [3:0] code, input logic ena);
        return ena ? (16'h0001 << code) : 16'h0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream ready generator.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare every output handshake against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word actual=%04h required=none", d);
                    end else begin
                        mon_e = sb.pop_front();
                        $display("word code=%0d d=%04h done=%0b", out_code, d, sweep_done);
                        check("out_code", 32'(out_code), 32'(mon_e.code));
                        check("d", 32'(d), 32'(mon_e.word));
                        check("sweep_done", 32'(sweep_done), 32'(mon_e.last));
                        if (mon_e.last) sweeps_done_seen++;
                    end
                end else if (sweep_done) begin
                    checks++;
                    failures++;
                    $display("FAIL sweep_done_no_handshake actual=1 required=0");
                end
            end
        end
    end

    // Offer one code (good parity) until accepted.
    task automatic send(input logic [3:0] ca, input logic ce);
        int n;
        n = 0;
        a = ca;
        en = ce;
        in_valid = 1'b1;
`ifdef DECODER_PARITY_EN
        in_par = ^ca;
`endif
        forever begin
            @(negedge clk);
            check("in_ready_idle", 32'(in_ready), 32'(!sweep_start && (!out_valid || out_ready)));
            if (in_ready) begin
                sb.push_back('{code: ca, word: model_word(ca, ce), last: 1'b0});
                break;
            end
            n++;
            if (n > 300) begin
                check("send_timeout", 32'(n), 32'(0));
                break;
            end
            tick();
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Run a full sweep; optionally require 16 back-to-back valid cycles.
    task automatic sweep(input logic se, input logic consec);
        int cyc;
        a = 4'($urandom);
        en = se;
        in_valid = 1'b1;   // must lose to sweep_start
`ifdef DECODER_PARITY_EN
        in_par = ^a;
`endif
        sweep_start = 1'b1;
        @(negedge clk);
        check("in_ready_on_start", 32'(in_ready), 32'(0));
        for (int i = 0; i < 16; i++) begin
            sb.push_back('{code: 4'(i), word: model_word(4'(i), se), last: (i == 15)});
        end
        sweeps_started++;
        tick();
        sweep_start = 1'b0;
        in_valid = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (consec && cyc < 16) check("sweep_consecutive_valid", 32'(out_valid), 32'(1));
            if (sweeps_done_seen == sweeps_started) break;
            check("in_ready_in_sweep", 32'(in_ready), 32'(0));
            cyc++;
            if (cyc > 800) begin
                check("sweep_timeout", 32'(cyc), 32'(0));
                break;
            end
        end
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        rdy_mode = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'(0));
        tick();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b1;
        a = 4'd9;
        en = 1'b1;
        sweep_start = 1'b0;
`ifdef DECODER_PARITY_EN
        in_par = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_d", 32'(d), 32'(0));
        check("rst_out_code", 32'(out_code), 32'(0));
        check("rst_sweep_done", 32'(sweep_done), 32'(0));
`ifdef DECODER_PARITY_EN
        check("rst_err", 32'(err), 32'(0));
`endif
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'(1));
        tick();

        // Single decode, exactly one valid cycle.
        send(4'd9, 1'b1);
        @(negedge clk);
        check("single_valid", 32'(out_valid), 32'(1));
        check("single_d", 32'(d), 32'h0200);
        @(negedge clk);
        check("single_valid_once", 32'(out_valid), 32'(0));
        tick();

        // Backpressure: word 3 stalls, 5 waits, then both drain in order.
        rdy_mode = 2;
        tick();
        tick();
        send(4'd3, 1'b1);
        a = 4'd5;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'(0));
        check("bp_hold_d", 32'(d), 32'h0008);
        tick();
        @(negedge clk);
        check("bp_hold_d2", 32'(d), 32'h0008);
        check("bp_hold_valid", 32'(out_valid), 32'(1));
        rdy_mode = 0;
        send(4'd5, 1'b1);
        @(negedge clk);
        check("bp_release_d", 32'(d), 32'h0020);
        tick();

        // Disabled decode.
        send(4'd7, 1'b0);
        @(negedge clk);
        check("dis_valid", 32'(out_valid), 32'(1));
        check("dis_d", 32'(d), 32'h0000);
        tick();
        drain();

        // Sweeps.
        tick();
        sweep(1'b1, 1'b1);
        rdy_mode = 1;
        sweep(1'b1, 1'b0);
        sweep(1'b0, 1'b0);

        // Random mix.
        for (int k = 0; k < 60; k++) begin
            rdy_mode = int'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                rdy_mode = 1;
                sweep(1'($urandom_range(0, 1)), 1'b0);
            end else begin
                send(4'($urandom), 1'($urandom_range(0, 3) != 0));
            end
        end
        drain();

        // Reset abort during sweep word 6.
        tick();
        a = 4'd0;
        en = 1'b1;
        sweep_start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sb.push_back('{code: 4'(i), word: model_word(4'(i), 1'b1), last: (i == 15)});
        end
        sweeps_started++;
        tick();
        sweep_start = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid && out_code == 4'd6) break;
            n++;
            if (n > 100) begin
                check("abort_wait_timeout", 32'(n), 32'(0));
                break;
            end
        end
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'(0));
        check("abort_d", 32'(d), 32'(0));
        check("abort_sweep_done", 32'(sweep_done), 32'(0));
        sb.delete();
        sweeps_started = sweeps_done_seen;
        @(negedge clk);
        check("abort_hold_done", 32'(sweep_done), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle_in_ready", 32'(in_ready), 32'(1));
        check("abort_idle_valid", 32'(out_valid), 32'(0));
        tick();

`ifdef DECODER_PARITY_EN
        // Bad parity is handshaken, dropped and sets the sticky error.
        a = 4'b0011;
        en = 1'b1;
        in_par = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("par_in_ready", 32'(in_ready), 32'(1));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("par_no_valid", 32'(out_valid), 32'(0));
        check("par_err", 32'(err), 32'(1));
        tick();
        send(4'b0001, 1'b1);
        @(negedge clk);
        check("par_good_d", 32'(d), 32'h0002);
        check("par_err_sticky", 32'(err), 32'(1));
        tick();
`endif

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
